// File: rtl/spi_frame_rx.sv
// SPI slave front end: synchronizes the host pins onto clk, assembles 16-bit
// address/data frames, strobes register writes and serves read bytes on spi_miso.
module spi_frame_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sck,
  input  logic       spi_en,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       frame_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  localparam logic [4:0] CNT_MAX   = 5'd17;
  localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

  logic [SYNC_STAGES-1:0] sck_sync_q, en_sync_q, mosi_sync_q;
  logic                   sck_d1_q, en_d1_q;
  logic                   sck_s, en_s, mosi_s;
  logic                   sck_rise, sck_fall, en_fall;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] shift_q, shift_d, shift_nx;
  logic [7:0]  tx_q, tx_d;
  logic        load_q, load_d;
  logic        miso_q, miso_d;
  logic        wr_valid_q, wr_valid_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [7:0]  rd_addr_q, rd_addr_d;
  logic        err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= '0;
      en_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_d1_q    <= 1'b0;
      en_d1_q     <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      en_sync_q   <= {en_sync_q[SYNC_STAGES-2:0], spi_en};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sck_d1_q    <= sck_s;
      en_d1_q     <= en_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign en_s     = en_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d1_q;
  assign sck_fall = ~sck_s & sck_d1_q;
  assign en_fall  = ~en_s & en_d1_q;
  assign shift_nx = {shift_q[14:0], mosi_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // IDLE starts on the enable level so a re-rise seen during DONE is not lost.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en_s) state_d = SHIFT;
      SHIFT:   if (en_fall) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    load_d     = 1'b0;
    miso_d     = miso_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_addr_d  = rd_addr_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (en_s) begin
          cnt_d   = '0;
          shift_d = '0;
          tx_d    = '0;
        end
      end
      SHIFT: begin
        if (load_q) tx_d = rd_data;
        if (sck_rise && en_s) begin
          shift_d = shift_nx;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd7 && shift_nx[7]) begin
            rd_addr_d = {1'b0, shift_nx[6:0]};
            load_d    = 1'b1;
          end
        end
        if (sck_fall && en_s) begin
          if (cnt_q >= 5'd8 && cnt_q <= 5'd15) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end else begin
            miso_d = 1'b0;
          end
        end
      end
      DONE: begin
        miso_d = 1'b0;
        if (cnt_q != 5'd16) begin
          err_d = 1'b1;
        end else if (!shift_q[15]) begin
          if ({1'b0, shift_q[14:8]} < NUM_REGS_B) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = {1'b0, shift_q[14:8]};
            wr_data_d  = shift_q[7:0];
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: miso_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      load_q     <= 1'b0;
      miso_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_addr_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      load_q     <= load_d;
      miso_q     <= miso_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_addr_q  <= rd_addr_d;
      err_q      <= err_d;
    end
  end

  assign spi_miso  = miso_q;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_addr   = rd_addr_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Bench for spi_frame_rx: directed vector table, hand-written corner sequences
// and random frames checked against a frame-level reference model.
module tb_spi_frame_rx;
  localparam int SS = 2;
  localparam int NR = 8;
  localparam int H  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       spi_sck = 1'b0, spi_en = 1'b0, spi_mosi = 1'b0;
  logic       spi_miso, wr_valid, frame_err;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  logic [7:0] mem [128];

  spi_frame_rx #(.SYNC_STAGES(SS), .NUM_REGS(NR)) dut (
    .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_en(spi_en),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .frame_err(frame_err)
  );

  assign rd_data = mem[rd_addr[6:0]];
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int wv_cnt = 0, fe_cnt = 0;
  logic [15:0] wq [$];
  logic [7:0]  m_wa = 8'h00, m_wd = 8'h00;

  always @(posedge clk) begin
    #1;
    if (wr_valid) begin
      wv_cnt++;
      wq.push_back({wr_addr, wr_data});
    end
    if (frame_err) fe_cnt++;
  end

  typedef struct {
    logic [31:0] word;
    int          n;
    logic        exp_wr;
    logic        exp_err;
    logic [7:0]  ea;
    logic [7:0]  ed;
    logic        is_rd;
    logic [7:0]  em;
    logic [7:0]  era;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_frame();
    @(negedge clk);
    spi_en = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [31:0] w, input int n, output logic [7:0] mb);
    mb = 8'h00;
    for (int i = 0; i < n; i++) begin
      spi_mosi = w[n-1-i];
      repeat (H) @(negedge clk);
      if (i >= 8 && i < 16) mb[15-i] = spi_miso;
      spi_sck = 1'b1;
      repeat (H) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic end_frame();
    repeat (H) @(negedge clk);
    spi_mosi = 1'b0;
    spi_en   = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (lat < 0 && (wr_valid || frame_err)) lat = k;
    end
  endtask

  task automatic run_frame(input string name, input vec_t v);
    int wv0, fe0, lat;
    logic [7:0] mb;
    wq.delete();
    wv0 = wv_cnt;
    fe0 = fe_cnt;
    start_frame();
    shift_bits(v.word, v.n, mb);
    end_frame();
    wait_result(lat);
    check({name, " wr_count"}, wv_cnt - wv0, {31'd0, v.exp_wr});
    check({name, " err_count"}, fe_cnt - fe0, {31'd0, v.exp_err});
    check({name, " latency"}, lat, (v.exp_wr || v.exp_err) ? SS + 2 : -1);
    if (v.exp_wr) begin
      m_wa = v.ea;
      m_wd = v.ed;
      if (wq.size() > 0) check({name, " strobe_addr_data"}, {16'd0, wq.pop_front()}, {16'd0, v.ea, v.ed});
    end
    check({name, " wr_addr_hold"}, {24'd0, wr_addr}, {24'd0, m_wa});
    check({name, " wr_data_hold"}, {24'd0, wr_data}, {24'd0, m_wd});
    if (v.is_rd) begin
      check({name, " miso_byte"}, {24'd0, mb}, {24'd0, v.em});
      check({name, " rd_addr"}, {24'd0, rd_addr}, {24'd0, v.era});
    end
  endtask

  function automatic vec_t model(input logic [31:0] w, input int n);
    vec_t v;
    logic rw;
    logic [6:0] a;
    v = '{word: w, n: n, exp_wr: 1'b0, exp_err: 1'b0, ea: 8'h00, ed: 8'h00,
          is_rd: 1'b0, em: 8'h00, era: 8'h00};
    rw = w[15];
    a  = w[14:8];
    if (n != 16) begin
      v.exp_err = 1'b1;
    end else if (rw) begin
      v.is_rd = 1'b1;
      v.era   = {1'b0, a};
      v.em    = mem[a];
    end else if (int'(a) < NR) begin
      v.exp_wr = 1'b1;
      v.ea     = {1'b0, a};
      v.ed     = w[7:0];
    end else begin
      v.exp_err = 1'b1;
    end
    return v;
  endfunction

  initial begin
    #500000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, wv0, fe0;
    logic [7:0] mb;
    vec_t v;
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    mem[3] = 8'h5C;

    #3 rst_n = 1'b0;
    #1;
    check("reset miso", {31'd0, spi_miso}, 0);
    check("reset wr_valid", {31'd0, wr_valid}, 0);
    check("reset frame_err", {31'd0, frame_err}, 0);
    check("reset wr_addr", {24'd0, wr_addr}, 0);
    check("reset wr_data", {24'd0, wr_data}, 0);
    check("reset rd_addr", {24'd0, rd_addr}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    tbl[0] = '{32'h02A5,  16, 1'b1, 1'b0, 8'h02, 8'hA5, 1'b0, 8'h00, 8'h00};
    tbl[1] = '{32'h8300,  16, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h5C, 8'h03};
    tbl[2] = '{32'h0933,  16, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00};
    tbl[3] = '{32'h5A5A5, 20, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00};
    tbl[4] = '{32'h0711,  16, 1'b1, 1'b0, 8'h07, 8'h11, 1'b0, 8'h00, 8'h00};
    for (int i = 0; i < 5; i++) run_frame($sformatf("vec%0d", i), tbl[i]);

    // 12-bit abort, enable low for one clk, then a full write frame
    wq.delete();
    wv0 = wv_cnt;
    fe0 = fe_cnt;
    start_frame();
    shift_bits(32'hABC, 12, mb);
    end_frame();
    @(negedge clk);
    spi_en = 1'b1;
    repeat (H) @(negedge clk);
    shift_bits(32'h0481, 16, mb);
    end_frame();
    wait_result(lat);
    check("abort err_count", fe_cnt - fe0, 1);
    check("abort wr_count", wv_cnt - wv0, 1);
    check("abort latency", lat, SS + 2);
    if (wq.size() > 0) check("abort strobe", {16'd0, wq.pop_front()}, 32'h0481);
    m_wa = 8'h04;
    m_wd = 8'h81;

    // reset pulse in the middle of a read frame
    wv0 = wv_cnt;
    fe0 = fe_cnt;
    start_frame();
    shift_bits(32'h3FF, 10, mb);
    @(negedge clk);
    rst_n = 1'b0;
    spi_en = 1'b0;
    spi_mosi = 1'b0;
    #1;
    check("midrst wr_addr", {24'd0, wr_addr}, 0);
    check("midrst wr_data", {24'd0, wr_data}, 0);
    check("midrst rd_addr", {24'd0, rd_addr}, 0);
    check("midrst miso", {31'd0, spi_miso}, 0);
    m_wa = 8'h00;
    m_wd = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst no_strobe", wv_cnt - wv0, 0);
    check("midrst no_err", fe_cnt - fe0, 0);
    run_frame("post_reset", model(32'h0001, 16));

    for (int r = 0; r < 30; r++) begin
      logic [31:0] w;
      int n;
      logic [6:0] a;
      a = 7'($urandom_range(0, 15));
      w = {16'($urandom) & 16'h0000, 1'($urandom), a, 8'($urandom)};
      n = ($urandom_range(0, 3) != 0) ? 16 : int'($urandom_range(1, 20));
      if (n != 16) w = $urandom;
      mem[w[14:8]] = 8'($urandom);
      v = model(w, n);
      run_frame($sformatf("rnd%0d", r), v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_frame_rx.md
Name: spi_frame_rx

Overview:
Upstream front end for the register file and PWM channels. It oversamples the external SPI pins (spi_sck, spi_en, spi_mosi) on the internal HFOSC clock, assembles 16-bit frames (address byte then data byte, MSB first) and issues a single-cycle write strobe. Read frames return a register byte on spi_miso. All SPI inputs are asynchronous to clk; this block is the only place they are synchronized.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the synchronizer on each SPI input (minimum 2).
NUM_REGS, 8, number of valid register addresses; addresses at or above this value are rejected.

Ports:
clk  input  1  internal clock (HFOSC domain), rising edge.
rst_n  input  1  asynchronous active-low reset.
spi_sck  input  1  SPI clock from the host, asynchronous; idle low (mode 0).
spi_en  input  1  frame enable, active high, asynchronous.
spi_mosi  input  1  host-to-device data, sampled on spi_sck rising edge.
spi_miso  output  1  device-to-host data, updated on spi_sck falling edge.
wr_valid  output  1  one-cycle write strobe.
wr_addr  output  8  register address; valid while wr_valid is high.
wr_data  output  8  register data; valid while wr_valid is high.
rd_addr  output  8  address of the register being read; held stable from the 8th bit to the end of the frame.
rd_data  input  8  register contents at rd_addr, combinational from the register file.
frame_err  output  1  one-cycle pulse when a frame is rejected.

Behaviour:
- Reset (async assert, sync release): all synchronizer stages 0, bit counter 0, shift registers 0, spi_miso 0, wr_valid 0, wr_addr 0, wr_data 0, rd_addr 0, frame_err 0, state IDLE.
- Synchronizers: each SPI input passes through SYNC_STAGES flops. Edge detection compares the last sync stage with one extra registered copy. All decisions use synchronized signals only.
- Frame format: bit 15 = R/W (1 = read), bits 14:8 = address (7-bit, zero-extended onto wr_addr/rd_addr), bits 7:0 = data. First bit received is bit 15.
- States:
  - IDLE: spi_miso = 0. A synchronized spi_en rise clears the bit counter and goes to SHIFT.
  - SHIFT: on each synchronized sck rise, shift in mosi and increment the 5-bit counter, which saturates at 17.
    - When the counter reaches 8 and R/W = 1: rd_addr takes the address bits; on the next clk, load rd_data into the output shift register.
    - On each sck fall while counter is 8 to 15: spi_miso drives the output shift register MSB, then the register shifts left. Otherwise spi_miso = 0.
    - A synchronized spi_en fall goes to DONE.
  - DONE (one cycle), then return to IDLE:
    - Counter == 16, write, and address < NUM_REGS: wr_valid = 1 with wr_addr/wr_data.
    - Counter == 16 and read: no strobe and no error.
    - Counter != 16, or address >= NUM_REGS: frame_err = 1, no wr_valid.
- Latency: wr_valid rises SYNC_STAGES+2 clk cycles after spi_en falls at the pin. wr_addr/wr_data hold their values until the next write.
- spi_en dropping mid-byte aborts the frame (error path above). spi_en re-rising during DONE is detected on the following cycle and starts a new frame with no lost bits.
- sck edges while spi_en is low are ignored.
- Host constraint: sck period must be at least 4 clk periods. Faster sck is out of spec; the bench does not check it.
- rst_n asserted mid-frame discards the frame with no strobe and no error.

Test Plan:
- Write frame 0x02,0xA5, sck = clk/8 -> single wr_valid with wr_addr=0x02, wr_data=0xA5, exactly SYNC_STAGES+2 clk after spi_en falls; frame_err stays 0.
- Read frame 0x83 with rd_data model returning 0x5C -> rd_addr=0x03; spi_miso bits 8–15 sampled by host = 0x5C; no wr_valid.
- Address 0x09 write (NUM_REGS=8) -> frame_err pulse, no wr_valid, wr_addr/wr_data keep previous value.
- 12-bit aborted frame, then an immediate valid frame 0x04,0x81 -> one frame_err, then wr_valid with 0x04/0x81.
- 20-bit frame -> counter saturates, frame_err pulse, no write.
- rst_n pulsed low after 10 bits -> outputs at reset values; the next full frame 0x00,0x01 writes correctly.
